// File: rtl/vga_pkg.sv
// Shared VGA constants for the pixel fetch path.
// Holds the visible-area size, frame-buffer size, RGB565 field widths,
// the eight colour-bar values and the double-buffer swap state type.
// barColour() maps a screen column to its 80-pixel-wide colour bar.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int FB_W     = 160;
    localparam int FB_H     = 120;

    localparam int RED_W    = 5;
    localparam int GREEN_W  = 6;
    localparam int BLUE_W   = 5;

    localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
    localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
    localparam logic [15:0] BAR_CYAN    = 16'h07FF;
    localparam logic [15:0] BAR_GREEN   = 16'h07E0;
    localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
    localparam logic [15:0] BAR_RED     = 16'hF800;
    localparam logic [15:0] BAR_BLUE    = 16'h001F;
    localparam logic [15:0] BAR_BLACK   = 16'h0000;

    typedef enum logic {
        SWAP_IDLE,
        SWAP_PENDING
    } swapState_e;

    // 80 is not a power of two, so the bar index comes from a compare chain
    // rather than from slicing the column; columns past 639 fall into black.
    function automatic logic [15:0] barColour(input logic [9:0] col);
        logic [15:0] colour;
        if      (col < 10'd80)  colour = BAR_WHITE;
        else if (col < 10'd160) colour = BAR_YELLOW;
        else if (col < 10'd240) colour = BAR_CYAN;
        else if (col < 10'd320) colour = BAR_GREEN;
        else if (col < 10'd400) colour = BAR_MAGENTA;
        else if (col < 10'd480) colour = BAR_RED;
        else if (col < 10'd560) colour = BAR_BLUE;
        else                    colour = BAR_BLACK;
        return colour;
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register used to keep control signals aligned with the
// pixel pipeline.
// Ports:
//   clk_i   - clock, rising edge
//   rst_ni  - asynchronous active-low reset, loads RESET_VAL into every stage
//   data_i  - WIDTH-bit input
//   data_o  - data_i delayed by DEPTH clocks
module sync_delay_line #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    // Reset loads the inactive level so nothing spurious leaves the line
    // while the pipeline refills.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RESET_VAL;
            end
        end else begin
            stage_q[0] <= data_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign data_o = stage_q[DEPTH-1];

endmodule

// File: rtl/pixel_fetch_pipeline.sv
// Three-stage pixel fetch: column/row -> frame-buffer address -> RAM data ->
// RGB565 output, with syncs delayed to match and a double-buffer swap that
// only takes effect at the start of a frame.
// Ports:
//   clk_25MHz, reset (async, active-low)
//   x, y, active_video, hsync_in, vsync_in  - timing generator inputs
//   pattern_en  - select internal colour bars instead of frame-buffer data
//   swap_req    - pulse requesting a buffer swap; swap_ack pulses when done
//   fb_addr     - {buf_sel, pixel index}; fb_data returns one clock later
//   hsync, vsync, red, green, blue - outputs, PIPE_LAT clocks after input
module pixel_fetch_pipeline #(
    parameter int FB_W        = vga_pkg::FB_W,
    parameter int FB_H        = vga_pkg::FB_H,
    parameter int SCALE_SHIFT = 2,
    parameter int PIPE_LAT    = 3
) (
    input  logic                        clk_25MHz,
    input  logic                        reset,
    input  logic [9:0]                  x,
    input  logic [9:0]                  y,
    input  logic                        active_video,
    input  logic                        hsync_in,
    input  logic                        vsync_in,
    input  logic                        pattern_en,
    input  logic                        swap_req,
    output logic                        swap_ack,
    output logic [15:0]                 fb_addr,
    input  logic [15:0]                 fb_data,
    output logic                        hsync,
    output logic                        vsync,
    output logic [vga_pkg::RED_W-1:0]   red,
    output logic [vga_pkg::GREEN_W-1:0] green,
    output logic [vga_pkg::BLUE_W-1:0]  blue
);

    import vga_pkg::*;

    // Row stride FB_W is built as the sum of two powers of two (160 = 128 + 32)
    // so the row base needs only shifts and one adder.
    localparam int IDX_W   = $clog2(FB_W * FB_H);
    localparam int SH_HI   = $clog2(FB_W + 1) - 1;
    localparam int ROW_REM = FB_W - (1 << SH_HI);
    localparam int SH_LO   = (ROW_REM == 0) ? 0 : $clog2(ROW_REM + 1) - 1;

    logic [9:0]       xr, yr;
    logic [16:0]      rowBase;
    logic [IDX_W-1:0] pixIdx_d;

    swapState_e       state_q;
    logic             bufSel_q;
    logic             swapAck_q;
    logic             vsyncPrev_q;
    logic             frameEdge;

    logic [15:0]      fbAddr_q;
    logic [15:0]      patColour_q;
    logic [15:0]      patColourDly_q;
    logic [15:0]      pixel_d;
    logic [15:0]      pixel_q;

    logic [1:0]       syncDly;
    logic [1:0]       ctrlDly;
    logic             activeDly;
    logic             patEnDly;

    assign xr = x >> SCALE_SHIFT;
    assign yr = y >> SCALE_SHIFT;

    always_comb begin
        rowBase  = ({7'd0, yr} << SH_HI)
                 + ((ROW_REM == 0) ? 17'd0 : ({7'd0, yr} << SH_LO));
        pixIdx_d = IDX_W'(rowBase + {7'd0, xr});
    end

    // Frame boundary is the falling edge of vsync_in against its registered copy.
    assign frameEdge = vsyncPrev_q & ~vsync_in;

    // Swap FSM: a request waits in PENDING until the next frame boundary; one
    // arriving exactly on the boundary is honoured there. Further requests
    // while pending collapse into the same single toggle.
    always_ff @(posedge clk_25MHz or negedge reset) begin
        if (!reset) begin
            state_q     <= SWAP_IDLE;
            bufSel_q    <= 1'b0;
            swapAck_q   <= 1'b0;
            vsyncPrev_q <= 1'b1;
        end else begin
            vsyncPrev_q <= vsync_in;
            swapAck_q   <= 1'b0;
            case (state_q)
                SWAP_IDLE: begin
                    if (swap_req && frameEdge) begin
                        bufSel_q  <= ~bufSel_q;
                        swapAck_q <= 1'b1;
                    end else if (swap_req) begin
                        state_q <= SWAP_PENDING;
                    end
                end
                SWAP_PENDING: begin
                    if (frameEdge) begin
                        bufSel_q  <= ~bufSel_q;
                        swapAck_q <= 1'b1;
                        state_q   <= SWAP_IDLE;
                    end
                end
                default: state_q <= SWAP_IDLE;
            endcase
        end
    end

    // hsync/vsync ride the full pipeline; active/pattern select are needed one
    // stage earlier because they steer the final output register.
    sync_delay_line #(
        .WIDTH    (2),
        .DEPTH    (PIPE_LAT),
        .RESET_VAL(2'b11)
    ) uSyncDelay (
        .clk_i (clk_25MHz),
        .rst_ni(reset),
        .data_i({hsync_in, vsync_in}),
        .data_o(syncDly)
    );

    sync_delay_line #(
        .WIDTH    (2),
        .DEPTH    (PIPE_LAT - 1),
        .RESET_VAL(2'b00)
    ) uCtrlDelay (
        .clk_i (clk_25MHz),
        .rst_ni(reset),
        .data_i({active_video, pattern_en}),
        .data_o(ctrlDly)
    );

    assign activeDly = ctrlDly[1];
    assign patEnDly  = ctrlDly[0];

    always_comb begin
        pixel_d = 16'h0000;
        if (activeDly) begin
            pixel_d = patEnDly ? patColourDly_q : fb_data;
        end
    end

    // Stage 1 registers the address and the bar colour for this column; the
    // bar colour is held one more stage so it meets the RAM data at stage 3.
    always_ff @(posedge clk_25MHz or negedge reset) begin
        if (!reset) begin
            fbAddr_q       <= 16'h0000;
            patColour_q    <= 16'h0000;
            patColourDly_q <= 16'h0000;
            pixel_q        <= 16'h0000;
        end else begin
            fbAddr_q       <= {bufSel_q, pixIdx_d};
            patColour_q    <= barColour(x);
            patColourDly_q <= patColour_q;
            pixel_q        <= pixel_d;
        end
    end

    assign fb_addr  = fbAddr_q;
    assign swap_ack = swapAck_q;
    assign hsync    = syncDly[1];
    assign vsync    = syncDly[0];
    assign red      = pixel_q[15:11];
    assign green    = pixel_q[10:5];
    assign blue     = pixel_q[4:0];

endmodule

// File: tb/tb_pixel_fetch_pipeline.sv
// Testbench for pixel_fetch_pipeline: a behavioural RAM plus a reference
// model that predicts address, swap_ack and the delayed pixel/sync outputs.
module tb_pixel_fetch_pipeline;

    logic        clk_25MHz;
    logic        reset;
    logic [9:0]  x, y;
    logic        active_video, hsync_in, vsync_in, pattern_en, swap_req;
    logic        swap_ack;
    logic [15:0] fb_addr, fb_data;
    logic        hsync, vsync;
    logic [4:0]  red;
    logic [5:0]  green;
    logic [4:0]  blue;

    typedef struct packed {
        logic [15:0] rgb;
        logic        hs;
        logic        vs;
    } outS;

    outS         pipeQ[$];
    outS         expOut;
    logic [15:0] expAddr;
    logic        expAck;
    logic        modelBuf, modelPending, modelPrevVs;
    int          totalCount = 0;
    int          badCount   = 0;
    logic [15:0] mem [65536];

    pixel_fetch_pipeline dut (
        .clk_25MHz   (clk_25MHz),
        .reset       (reset),
        .x           (x),
        .y           (y),
        .active_video(active_video),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .pattern_en  (pattern_en),
        .swap_req    (swap_req),
        .swap_ack    (swap_ack),
        .fb_addr     (fb_addr),
        .fb_data     (fb_data),
        .hsync       (hsync),
        .vsync       (vsync),
        .red         (red),
        .green       (green),
        .blue        (blue)
    );

    initial clk_25MHz = 1'b0;
    always #20 clk_25MHz = ~clk_25MHz;

    // Synchronous frame-buffer RAM: data one clock after the address.
    always @(posedge clk_25MHz) fb_data <= mem[fb_addr];

    // Colour bars from the column: 80 pixels per bar, white..black.
    function automatic logic [15:0] refColour(input logic [9:0] col);
        logic [15:0] c;
        case (int'(col) / 80)
            0:       c = 16'hFFFF;
            1:       c = 16'hFFE0;
            2:       c = 16'h07FF;
            3:       c = 16'h07E0;
            4:       c = 16'hF81F;
            5:       c = 16'hF800;
            6:       c = 16'h001F;
            default: c = 16'h0000;
        endcase
        return c;
    endfunction

    task automatic modelReset();
        outS idle;
        idle = '{rgb: 16'h0000, hs: 1'b1, vs: 1'b1};
        pipeQ.delete();
        repeat (2) pipeQ.push_back(idle);
        modelBuf     = 1'b0;
        modelPending = 1'b0;
        modelPrevVs  = 1'b1;
        expAck       = 1'b0;
        expAddr      = 16'h0000;
    endtask

    // Drives one input sample (called at posedge+1), updates the model,
    // then advances to just after the edge that samples it.
    task automatic stepCycle(input logic [9:0] xi, input logic [9:0] yi,
                             input logic act, input logic hs, input logic vs,
                             input logic pat, input logic sreq);
        outS  s;
        int   idx;
        logic boundary, want;
        x = xi; y = yi; active_video = act; hsync_in = hs; vsync_in = vs;
        pattern_en = pat; swap_req = sreq;
        idx     = (int'(yi) / 4) * 160 + (int'(xi) / 4);
        expAddr = {modelBuf, idx[14:0]};
        s.hs = hs;
        s.vs = vs;
        if (!act)     s.rgb = 16'h0000;
        else if (pat) s.rgb = refColour(xi);
        else          s.rgb = mem[expAddr];
        boundary    = modelPrevVs && !vs;
        modelPrevVs = vs;
        want        = modelPending || sreq;
        if (boundary && want) begin
            modelBuf     = ~modelBuf;
            modelPending = 1'b0;
            expAck       = 1'b1;
        end else begin
            modelPending = want;
            expAck       = 1'b0;
        end
        pipeQ.push_back(s);
        expOut = pipeQ.pop_front();
        @(posedge clk_25MHz);
        #1;
    endtask

    task automatic idleStep(input logic vs);
        stepCycle(10'd0, 10'd0, 1'b0, 1'b1, vs, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        x = '0; y = '0; active_video = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
        pattern_en = 1'b0; swap_req = 1'b0;
        repeat (3) @(posedge clk_25MHz);
        #1;
        totalCount++; if (hsync !== 1'b1) begin badCount++; $display("FAIL reset_hsync: got %b want 1", hsync); end
        totalCount++; if (vsync !== 1'b1) begin badCount++; $display("FAIL reset_vsync: got %b want 1", vsync); end
        totalCount++; if ({red, green, blue} !== 16'h0000) begin badCount++; $display("FAIL reset_rgb: got %h want 0000", {red, green, blue}); end
        totalCount++; if (fb_addr !== 16'h0000) begin badCount++; $display("FAIL reset_addr: got %h want 0000", fb_addr); end
        totalCount++; if (swap_ack !== 1'b0) begin badCount++; $display("FAIL reset_ack: got %b want 0", swap_ack); end
        reset = 1'b1;
        modelReset();
    endtask

    task automatic test_basic_pixel();
        mem[16'h0141] = 16'hF800;
        stepCycle(10'd5, 10'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        totalCount++; if (fb_addr !== 16'h0141) begin badCount++; $display("FAIL basic_addr: got %h want 0141", fb_addr); end
        idleStep(1'b1);
        totalCount++; if (hsync !== 1'b1) begin badCount++; $display("FAIL basic_hsync_early: got %b want 1", hsync); end
        idleStep(1'b1);
        totalCount++; if (red !== 5'd31 || green !== 6'd0 || blue !== 5'd0) begin badCount++; $display("FAIL basic_rgb: got %0d/%0d/%0d want 31/0/0", red, green, blue); end
        totalCount++; if (hsync !== 1'b0) begin badCount++; $display("FAIL basic_hsync: got %b want 0", hsync); end
    endtask

    task automatic test_boundary_addr();
        mem[16'd19199] = 16'hFFFF;
        stepCycle(10'd639, 10'd479, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        totalCount++; if (fb_addr[14:0] !== 15'd19199) begin badCount++; $display("FAIL corner_addr: got %0d want 19199", fb_addr[14:0]); end
        stepCycle(10'd639, 10'd479, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        idleStep(1'b1);
        totalCount++; if ({red, green, blue} !== 16'h0000) begin badCount++; $display("FAIL corner_masked: got %h want 0000", {red, green, blue}); end
        idleStep(1'b1);
        totalCount++; if ({red, green, blue} !== 16'hFFFF) begin badCount++; $display("FAIL corner_active: got %h want FFFF", {red, green, blue}); end
    endtask

    task automatic test_pattern();
        logic [9:0]  xs   [9];
        logic [15:0] exps [9];
        xs   = '{10'd0, 10'd80, 10'd560, 10'd160, 10'd240, 10'd320, 10'd400, 10'd480, 10'd0};
        exps = '{16'hFFFF, 16'hFFE0, 16'h0000, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
        for (int i = 0; i < 11; i++) begin
            if (i < 9) stepCycle(xs[i], 10'd100, (i != 8), 1'b1, 1'b1, 1'b1, 1'b0);
            else       idleStep(1'b1);
            if (i >= 2) begin
                totalCount++;
                if ({red, green, blue} !== exps[i-2]) begin
                    badCount++;
                    $display("FAIL pattern_%0d: got %h want %h", i - 2, {red, green, blue}, exps[i-2]);
                end
            end
        end
    endtask

    task automatic test_swap_midframe();
        repeat (3) idleStep(1'b1);
        stepCycle(10'd100, 10'd200, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            stepCycle(10'(8 * i), 10'd200, 1'b1, 1'b1, 1'b1, 1'b0, (i == 3));
            totalCount++; if (fb_addr[15] !== 1'b0 || swap_ack !== 1'b0) begin badCount++; $display("FAIL swap_early_%0d: got sel=%b ack=%b want 0/0", i, fb_addr[15], swap_ack); end
        end
        idleStep(1'b0);
        totalCount++; if (swap_ack !== 1'b1) begin badCount++; $display("FAIL swap_ack_edge: got %b want 1", swap_ack); end
        for (int i = 0; i < 4; i++) begin
            stepCycle(10'd40, 10'd40, 1'b1, 1'b1, (i == 3), 1'b0, 1'b0);
            totalCount++; if (fb_addr[15] !== 1'b1 || swap_ack !== 1'b0) begin badCount++; $display("FAIL swap_after_%0d: got sel=%b ack=%b want 1/0", i, fb_addr[15], swap_ack); end
        end
        repeat (3) idleStep(1'b1);
        idleStep(1'b0);
        idleStep(1'b0);
        totalCount++; if (fb_addr[15] !== 1'b1 || swap_ack !== 1'b0) begin badCount++; $display("FAIL swap_single_toggle: got sel=%b ack=%b want 1/0", fb_addr[15], swap_ack); end
        idleStep(1'b1);
    endtask

    task automatic test_swap_coincident();
        repeat (2) idleStep(1'b1);
        stepCycle(10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        totalCount++; if (swap_ack !== 1'b1) begin badCount++; $display("FAIL coinc_ack: got %b want 1", swap_ack); end
        idleStep(1'b0);
        totalCount++; if (fb_addr[15] !== 1'b0 || swap_ack !== 1'b0) begin badCount++; $display("FAIL coinc_after: got sel=%b ack=%b want 0/0", fb_addr[15], swap_ack); end
        repeat (2) idleStep(1'b1);
    endtask

    task automatic test_reset_pending();
        idleStep(1'b0);
        totalCount++; if (swap_ack !== 1'b0) begin badCount++; $display("FAIL rstp_noreq_ack: got %b want 0", swap_ack); end
        idleStep(1'b1);
        stepCycle(10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        idleStep(1'b1);
        stepCycle(10'd20, 10'd20, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        mem[expAddr] = 16'hABCD;
        stepCycle(10'd20, 10'd20, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        stepCycle(10'd20, 10'd20, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        totalCount++; if (hsync !== 1'b0 || fb_addr[15] !== 1'b1) begin badCount++; $display("FAIL rstp_pre: got hs=%b sel=%b want 0/1", hsync, fb_addr[15]); end
        #5;
        reset = 1'b0;
        #1;
        totalCount++; if (hsync !== 1'b1 || vsync !== 1'b1) begin badCount++; $display("FAIL rstp_syncs: got %b%b want 11", hsync, vsync); end
        totalCount++; if ({red, green, blue} !== 16'h0000) begin badCount++; $display("FAIL rstp_rgb: got %h want 0000", {red, green, blue}); end
        totalCount++; if (fb_addr !== 16'h0000 || swap_ack !== 1'b0) begin badCount++; $display("FAIL rstp_addr_ack: got %h/%b want 0000/0", fb_addr, swap_ack); end
        repeat (2) @(posedge clk_25MHz);
        #1;
        reset = 1'b1;
        modelReset();
        idleStep(1'b1);
        idleStep(1'b0);
        totalCount++; if (swap_ack !== 1'b0) begin badCount++; $display("FAIL rstp_lost_ack: got %b want 0", swap_ack); end
        stepCycle(10'd4, 10'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        totalCount++; if (fb_addr[15] !== 1'b0) begin badCount++; $display("FAIL rstp_bufsel: got %b want 0", fb_addr[15]); end
        idleStep(1'b1);
    endtask

    task automatic test_random();
        logic [9:0] rx, ry;
        logic       act, vs;
        for (int c = 0; c < 600; c++) begin
            rx  = 10'($urandom_range(0, 799));
            ry  = 10'($urandom_range(0, 524));
            act = (rx < 10'd640 && ry < 10'd480) ? ($urandom_range(0, 3) != 0) : 1'b0;
            vs  = ((c % 60) >= 3);
            stepCycle(rx, ry, act, ($urandom_range(0, 7) != 0), vs,
                      ($urandom_range(0, 2) == 0), ($urandom_range(0, 24) == 0));
            totalCount++; if (fb_addr !== expAddr) begin badCount++; $display("FAIL rand_addr@%0d: got %h want %h", c, fb_addr, expAddr); end
            totalCount++; if (swap_ack !== expAck) begin badCount++; $display("FAIL rand_ack@%0d: got %b want %b", c, swap_ack, expAck); end
            totalCount++; if ({red, green, blue} !== expOut.rgb) begin badCount++; $display("FAIL rand_rgb@%0d: got %h want %h", c, {red, green, blue}, expOut.rgb); end
            totalCount++; if (hsync !== expOut.hs || vsync !== expOut.vs) begin badCount++; $display("FAIL rand_sync@%0d: got %b%b want %b%b", c, hsync, vsync, expOut.hs, expOut.vs); end
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        test_reset();
        test_basic_pixel();
        test_boundary_addr();
        test_pattern();
        test_swap_midframe();
        test_swap_coincident();
        test_reset_pending();
        test_random();
        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
